// File: rtl/bank_isu_refill_ctrl.sv
`default_nettype none
// ============================================================================
// bank_isu_refill_ctrl : tracks in-flight linefills per {set,way} and
// assembles BIU read beats into whole lines for the issue queue.
// Revision : 1.0
// ============================================================================
module bank_isu_refill_ctrl #(
    parameter int SET_W  = 3,
    parameter int WAY_W  = 3,
    parameter int BEAT_W = 256,
    parameter int BEATS  = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      alloc_valid_i,
    output logic                      alloc_ready_o,
    input  logic [SET_W-1:0]          alloc_set_i,
    input  logic [WAY_W-1:0]          alloc_way_i,
    input  logic [SET_W-1:0]          lookup_set_i,
    input  logic [WAY_W-1:0]          lookup_way_i,
    output logic                      lookup_inflight_o,
    input  logic                      biu_rvalid_i,
    output logic                      biu_rready_o,
    input  logic [BEAT_W-1:0]         biu_rdata_i,
    input  logic [SET_W+WAY_W-1:0]    biu_rid_i,
    input  logic                      biu_rlast_i,
    output logic                      fill_valid_o,
    input  logic                      fill_ready_i,
    output logic [SET_W+WAY_W-1:0]    fill_id_o,
    output logic [BEAT_W*BEATS-1:0]   fill_data_o,
    output logic                      err_unexp_o,
    output logic                      err_len_o,
    output logic [SET_W+WAY_W:0]      inflight_cnt_o
);

    localparam int ID_W    = SET_W + WAY_W;
    localparam int ENTRIES = 1 << ID_W;
    localparam int LINE_W  = BEAT_W * BEATS;
    localparam int CNT_W   = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ENTRIES-1:0]  inflight;
    logic [ID_W-1:0]     cur_id;
    logic [CNT_W-1:0]    beat_cnt;
    logic [LINE_W-1:0]   line;

    logic [ID_W-1:0]     alloc_id;
    logic                alloc_fire;
    logic                fill_fire;
    logic                beat_acc;
    logic                rid_known;
    logic                store_en;
    logic                start_line;
    logic [CNT_W-1:0]    store_slot;
    logic                unexp;
    logic                len_err;

    assign alloc_id          = {alloc_set_i, alloc_way_i};
    assign alloc_ready_o     = ~inflight[alloc_id];
    assign alloc_fire        = alloc_valid_i & alloc_ready_o;
    assign lookup_inflight_o = inflight[{lookup_set_i, lookup_way_i}];
    assign biu_rready_o      = (state != HOLD);
    assign beat_acc          = biu_rvalid_i & biu_rready_o;
    // Registered bits only: a beat racing its own allocation counts as unexpected.
    assign rid_known         = inflight[biu_rid_i];
    assign fill_valid_o      = (state == HOLD);
    assign fill_fire         = fill_valid_o & fill_ready_i;
    assign fill_id_o         = cur_id;
    assign fill_data_o       = line;
    assign len_err           = store_en & (biu_rlast_i != (store_slot == LAST_SLOT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        store_en   = 1'b0;
        start_line = 1'b0;
        store_slot = beat_cnt;
        unexp      = 1'b0;
        case (state)
            IDLE: begin
                if (beat_acc) begin
                    if (rid_known) begin
                        store_en   = 1'b1;
                        start_line = 1'b1;
                        store_slot = '0;
                        next_state = (BEATS == 1) ? HOLD : COLLECT;
                    end else begin
                        unexp = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (beat_acc) begin
                    if (rid_known && (biu_rid_i == cur_id)) begin
                        store_en = 1'b1;
                        if (beat_cnt == LAST_SLOT) begin
                            next_state = HOLD;
                        end
                    end else begin
                        unexp = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (fill_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight       <= '0;
            cur_id         <= '0;
            beat_cnt       <= '0;
            line           <= '0;
            inflight_cnt_o <= '0;
            err_unexp_o    <= 1'b0;
            err_len_o      <= 1'b0;
        end else begin
            err_unexp_o <= unexp;
            err_len_o   <= len_err;
            // alloc_id can never equal cur_id while the fill is pending.
            if (alloc_fire) begin
                inflight[alloc_id] <= 1'b1;
            end
            if (fill_fire) begin
                inflight[cur_id] <= 1'b0;
            end
            if (alloc_fire && !fill_fire) begin
                inflight_cnt_o <= inflight_cnt_o + (ID_W+1)'(1);
            end else if (fill_fire && !alloc_fire) begin
                inflight_cnt_o <= inflight_cnt_o - (ID_W+1)'(1);
            end
            if (start_line) begin
                cur_id   <= biu_rid_i;
                beat_cnt <= CNT_W'(1);
            end else if (store_en) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            for (int b = 0; b < BEATS; b++) begin
                if (store_en && (store_slot == CNT_W'(b))) begin
                    line[b*BEAT_W +: BEAT_W] <= biu_rdata_i;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bank_isu_refill_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bank_isu_refill_ctrl : directed and random stimulus against a
// transaction-level reference model of the refill controller.
// Revision : 1.0
// ============================================================================
module tb_bank_isu_refill_ctrl;

    localparam int SET_W   = 3;
    localparam int WAY_W   = 3;
    localparam int BEAT_W  = 256;
    localparam int BEATS   = 2;
    localparam int ID_W    = SET_W + WAY_W;
    localparam int ENTRIES = 1 << ID_W;
    localparam int LINE_W  = BEAT_W * BEATS;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [SET_W-1:0]  alloc_set;
    logic [WAY_W-1:0]  alloc_way;
    logic [SET_W-1:0]  lookup_set;
    logic [WAY_W-1:0]  lookup_way;
    logic              lookup_inflight;
    logic              biu_rvalid;
    logic              biu_rready;
    logic [BEAT_W-1:0] biu_rdata;
    logic [ID_W-1:0]   biu_rid;
    logic              biu_rlast;
    logic              fill_valid;
    logic              fill_ready;
    logic [ID_W-1:0]   fill_id;
    logic [LINE_W-1:0] fill_data;
    logic              err_unexp;
    logic              err_len;
    logic [ID_W:0]     inflight_cnt;

    bank_isu_refill_ctrl #(
        .SET_W (SET_W),
        .WAY_W (WAY_W),
        .BEAT_W(BEAT_W),
        .BEATS (BEATS)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .alloc_valid_i    (alloc_valid),
        .alloc_ready_o    (alloc_ready),
        .alloc_set_i      (alloc_set),
        .alloc_way_i      (alloc_way),
        .lookup_set_i     (lookup_set),
        .lookup_way_i     (lookup_way),
        .lookup_inflight_o(lookup_inflight),
        .biu_rvalid_i     (biu_rvalid),
        .biu_rready_o     (biu_rready),
        .biu_rdata_i      (biu_rdata),
        .biu_rid_i        (biu_rid),
        .biu_rlast_i      (biu_rlast),
        .fill_valid_o     (fill_valid),
        .fill_ready_i     (fill_ready),
        .fill_id_o        (fill_id),
        .fill_data_o      (fill_data),
        .err_unexp_o      (err_unexp),
        .err_len_o        (err_len),
        .inflight_cnt_o   (inflight_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: a set of in-flight ids and the line under assembly.
    bit              m_infl [ENTRIES];
    int              m_line_id = -1;
    logic [BEAT_W-1:0] m_beats [$];
    bit              m_unexp = 1'b0;
    bit              m_len   = 1'b0;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] rnd_beat();
        logic [BEAT_W-1:0] r;
        for (int i = 0; i < BEAT_W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Compare at negedge, then advance the model with the inputs held this cycle.
    task automatic cyc();
        logic [ID_W-1:0]   aid;
        logic [LINE_W-1:0] exp_data;
        bit full, aok, nu, nl;
        int cnt;
        @(negedge clk);
        aid  = {alloc_set, alloc_way};
        full = (m_line_id >= 0) && (m_beats.size() == BEATS);
        cnt  = 0;
        foreach (m_infl[i]) cnt += int'(m_infl[i]);
        chk("alloc_ready", LINE_W'(alloc_ready), LINE_W'(!m_infl[aid]));
        chk("lookup", LINE_W'(lookup_inflight), LINE_W'(m_infl[{lookup_set, lookup_way}]));
        chk("rready", LINE_W'(biu_rready), LINE_W'(!full));
        chk("fill_valid", LINE_W'(fill_valid), LINE_W'(full));
        chk("cnt", LINE_W'(inflight_cnt), LINE_W'(cnt));
        chk("err_unexp", LINE_W'(err_unexp), LINE_W'(m_unexp));
        chk("err_len", LINE_W'(err_len), LINE_W'(m_len));
        if (full) begin
            exp_data = '0;
            foreach (m_beats[i]) exp_data[i*BEAT_W +: BEAT_W] = m_beats[i];
            chk("fill_id", LINE_W'(fill_id), LINE_W'(m_line_id));
            chk("fill_data", fill_data, exp_data);
        end
        if (rst) begin
            foreach (m_infl[i]) m_infl[i] = 1'b0;
            m_line_id = -1;
            m_beats.delete();
            m_unexp = 1'b0;
            m_len   = 1'b0;
        end else begin
            aok = alloc_valid && !m_infl[aid];
            nu = 1'b0;
            nl = 1'b0;
            if (biu_rvalid && !full) begin
                if (!m_infl[biu_rid] || (m_line_id >= 0 && int'(biu_rid) != m_line_id)) begin
                    nu = 1'b1;
                end else begin
                    if (m_line_id < 0) m_line_id = int'(biu_rid);
                    nl = (biu_rlast != (m_beats.size() == BEATS - 1));
                    m_beats.push_back(biu_rdata);
                end
            end
            if (full && fill_ready) begin
                m_infl[m_line_id] = 1'b0;
                m_line_id = -1;
                m_beats.delete();
            end
            if (aok) m_infl[aid] = 1'b1;
            m_unexp = nu;
            m_len   = nl;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [ID_W-1:0] id);
        alloc_valid = 1'b1;
        {alloc_set, alloc_way} = id;
        cyc();
        alloc_valid = 1'b0;
    endtask

    task automatic do_beat(input logic [ID_W-1:0] id, input logic [BEAT_W-1:0] d, input logic last);
        biu_rvalid = 1'b1;
        biu_rid    = id;
        biu_rdata  = d;
        biu_rlast  = last;
        cyc();
        biu_rvalid = 1'b0;
    endtask

    task automatic sweep_lookup();
        for (int i = 0; i < ENTRIES; i++) begin
            {lookup_set, lookup_way} = ID_W'(i);
            {alloc_set, alloc_way}   = ID_W'(i);
            cyc();
        end
    endtask

    initial begin
        logic [BEAT_W-1:0] da, db;
        rst = 1'b1; alloc_valid = 1'b0; alloc_set = '0; alloc_way = '0;
        lookup_set = '0; lookup_way = '0; biu_rvalid = 1'b0; biu_rdata = '0;
        biu_rid = '0; biu_rlast = 1'b0; fill_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_fill_id", LINE_W'(fill_id), '0);
        chk("rst_fill_data", fill_data, '0);
        rst = 1'b0;
        sweep_lookup();

        // Basic two-beat line to {3,5}, with a held fill and a refused realloc.
        da = {64{4'hA}};
        db = {64{4'hB}};
        do_alloc(6'h1D);
        do_alloc(6'h1D);
        do_beat(6'h1D, da, 1'b0);
        do_beat(6'h1D, db, 1'b1);
        chk("dir_fill_valid", LINE_W'(fill_valid), LINE_W'(1));
        chk("dir_fill_id", LINE_W'(fill_id), LINE_W'(6'h1D));
        chk("dir_fill_data", fill_data, {db, da});
        biu_rvalid = 1'b1; biu_rid = 6'h1D; biu_rdata = rnd_beat();
        for (int i = 0; i < 5; i++) cyc();
        biu_rvalid = 1'b0;
        chk("dir_hold_data", fill_data, {db, da});
        fill_ready = 1'b1;
        do_alloc(6'h1D);
        fill_ready = 1'b0;
        do_alloc(6'h1D);
        chk("dir_cnt_realloc", LINE_W'(inflight_cnt), LINE_W'(1));

        // Unexpected id, then interleaved foreign beat and a length error.
        do_beat(6'h07, rnd_beat(), 1'b1);
        chk("dir_unexp", LINE_W'(err_unexp), LINE_W'(1));
        do_alloc(6'h09);
        do_alloc(6'h0A);
        do_beat(6'h09, rnd_beat(), 1'b1);
        chk("dir_len", LINE_W'(err_len), LINE_W'(1));
        do_beat(6'h0A, rnd_beat(), 1'b0);
        do_beat(6'h09, rnd_beat(), 1'b1);
        fill_ready = 1'b1;
        cyc();
        fill_ready = 1'b0;

        // Fill every entry, then swap a freed id against a clear.
        for (int i = 0; i < ENTRIES; i++) do_alloc(ID_W'(i));
        chk("dir_cnt_full", LINE_W'(inflight_cnt), LINE_W'(ENTRIES));
        do_beat(6'd5, rnd_beat(), 1'b0);
        do_beat(6'd5, rnd_beat(), 1'b1);
        fill_ready = 1'b1;
        cyc();
        fill_ready = 1'b0;
        do_beat(6'd6, rnd_beat(), 1'b0);
        do_beat(6'd6, rnd_beat(), 1'b1);
        fill_ready = 1'b1;
        do_alloc(6'd5);
        fill_ready = 1'b0;
        chk("dir_cnt_swap", LINE_W'(inflight_cnt), LINE_W'(ENTRIES - 1));

        // Reset with a partial line outstanding.
        do_beat(6'd7, rnd_beat(), 1'b0);
        rst = 1'b1;
        fill_ready = 1'b1;
        cyc();
        rst = 1'b0;
        fill_ready = 1'b0;
        sweep_lookup();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(399, 0) == 0);
            alloc_valid = $urandom_range(1, 0);
            {alloc_set, alloc_way}   = ID_W'($urandom_range(ENTRIES - 1, 0));
            {lookup_set, lookup_way} = ID_W'($urandom_range(ENTRIES - 1, 0));
            biu_rvalid  = ($urandom_range(2, 0) != 0);
            if (m_line_id >= 0 && $urandom_range(1, 0) == 1) biu_rid = ID_W'(m_line_id);
            else biu_rid = ID_W'($urandom_range(ENTRIES - 1, 0));
            biu_rdata   = rnd_beat();
            biu_rlast   = $urandom_range(1, 0);
            fill_ready  = $urandom_range(1, 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
